// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package imem_pkg;

    // Loader FSM states, in stream order
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } ld_state_t;

    localparam logic [3:0] WE_ALL = 4'b1111;
    localparam int         LEN_W  = 16;

    // A word count larger than the RAM depth cannot be loaded
    function automatic logic len_too_big(input logic [LEN_W-1:0] n, input int addr_w);
        return 32'(n) > (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Packs stream bytes into a 32-bit big-endian word (first byte lands in [31:24]).
// Latency: one cycle per shifted byte; the word is complete the cycle after the 4th shift.
// Backpressure: none of its own; the owning FSM decides when to shift.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_full
);

    logic [1:0] byte_cnt;

    // Shift bytes in from the bottom; the 2-bit counter wraps to 0 after the 4th byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_out <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word_out <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word_out <= {word_out[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // Three bytes held: the next shifted byte completes the word
    assign word_full = (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into the instruction RAM and holds the CPU in reset until done.
// Latency: 2 + 5*N cycles from start for N words with an unstalled stream.
// Backpressure: byte_ready is decoded from state; low outside LEN_HI/LEN_LO/DATA (including every WRITE cycle).
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [3:0]        wea,
    output logic [ADDR_W-1:0] addra,
    output logic [31:0]       dina,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    localparam logic [ADDR_W:0] IDX_ONE = 1;

    ld_state_t        state;
    logic [LEN_W-1:0] len;
    // One extra bit so a full-depth image ends at 2^ADDR_W without wrapping to 0
    logic [ADDR_W:0]  word_idx;
    logic [ADDR_W:0]  idx_next;
    logic [LEN_W-1:0] len_now;
    logic             accept;
    logic             start_ok;
    logic             pk_shift;
    logic             pk_full;
    logic [31:0]      pk_word;

    assign byte_ready = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA);
    assign accept     = byte_valid & byte_ready;
    assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign pk_shift   = accept && (state == ST_DATA);
    assign len_now    = {len[LEN_W-1:8], byte_data};
    assign idx_next   = word_idx + IDX_ONE;

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .shift_en  (pk_shift),
        .byte_in   (byte_data),
        .word_out  (pk_word),
        .word_full (pk_full)
    );

    // Loader FSM: length header, then alternating 4-byte gather and single write cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            len      <= '0;
            word_idx <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state    <= ST_LEN_HI;
                        len      <= '0;
                        word_idx <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len[LEN_W-1:8] <= byte_data;
                        state          <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len <= len_now;
                        if (len_now == '0)
                            state <= ST_DONE;
                        else if (len_too_big(len_now, ADDR_W))
                            state <= ST_ERR;
                        else
                            state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept && pk_full)
                        state <= ST_WRITE;
                end
                ST_WRITE: begin
                    word_idx <= idx_next;
                    if (32'(idx_next) == 32'(len))
                        state <= ST_DONE;
                    else
                        state <= ST_DATA;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status and RAM port are decoded from registered state only
    assign busy     = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                      (state == ST_DATA)   || (state == ST_WRITE);
    assign done     = (state == ST_DONE);
    assign err      = (state == ST_ERR);
    assign cpu_hold = ~done;
    assign wea      = (state == ST_WRITE) ? WE_ALL : 4'b0000;
    assign addra    = word_idx[ADDR_W-1:0];
    assign dina     = (state == ST_WRITE) ? pk_word : 32'h0;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a full-size instance plus a 4-word instance for the length limit.
// Expected RAM writes come from a byte-list model of the stream format.
// Randomised data and byte_valid gaps; every wait is bounded by a cycle budget.
module tb_imem_loader;

    localparam int AW_A = 10;
    localparam int AW_B = 2;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            a_start, a_valid, a_ready, a_busy, a_done, a_err, a_hold;
    logic [7:0]      a_data;
    logic [3:0]      a_wea;
    logic [AW_A-1:0] a_addra;
    logic [31:0]     a_dina;

    logic            b_start, b_valid, b_ready, b_busy, b_done, b_err, b_hold;
    logic [7:0]      b_data;
    logic [3:0]      b_wea;
    logic [AW_B-1:0] b_addra;
    logic [31:0]     b_dina;

    imem_loader #(.ADDR_W(AW_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .byte_valid(a_valid), .byte_data(a_data),
        .byte_ready(a_ready), .wea(a_wea), .addra(a_addra), .dina(a_dina),
        .busy(a_busy), .done(a_done), .err(a_err), .cpu_hold(a_hold)
    );

    imem_loader #(.ADDR_W(AW_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .byte_valid(b_valid), .byte_data(b_data),
        .byte_ready(b_ready), .wea(b_wea), .addra(b_addra), .dina(b_dina),
        .busy(b_busy), .done(b_done), .err(b_err), .cpu_hold(b_hold)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_a_addr[$];
    logic [31:0] wr_a_data[$];
    int          wr_b_addr[$];
    logic [31:0] wr_b_data[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_done, exp_err;
    int          exp_cycles;
    int          load_cycles;
    logic        post_done, post_hold;

    // Capture every RAM write; a write must use all byte lanes and must not coincide with byte_ready
    always @(negedge clk) begin
        if (a_wea !== 4'b0000) begin
            n_checks++;
            if (a_wea !== 4'b1111) begin n_fail++; $display("FAIL a_wea_lanes: got %b want 1111", a_wea); end
            n_checks++;
            if (a_ready !== 1'b0) begin n_fail++; $display("FAIL a_ready_in_write: got %b want 0", a_ready); end
            wr_a_addr.push_back(int'(a_addra));
            wr_a_data.push_back(a_dina);
        end
        if (b_wea !== 4'b0000) begin
            n_checks++;
            if (b_wea !== 4'b1111) begin n_fail++; $display("FAIL b_wea_lanes: got %b want 1111", b_wea); end
            n_checks++;
            if (b_ready !== 1'b0) begin n_fail++; $display("FAIL b_ready_in_write: got %b want 0", b_ready); end
            wr_b_addr.push_back(int'(b_addra));
            wr_b_data.push_back(b_dina);
        end
    end

    task automatic drive(input int sel, input logic st, input logic v, input logic [7:0] d);
        if (sel == 0) begin a_start = st; a_valid = v; a_data = d; end
        else          begin b_start = st; b_valid = v; b_data = d; end
    endtask

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? a_ready : b_ready;
    endfunction

    function automatic logic fin_of(input int sel);
        return (sel == 0) ? (a_done | a_err) : (b_done | b_err);
    endfunction

    // Stream format: 16-bit big-endian word count, then 4 bytes per word
    task automatic make_stream(input int n, output bq_t s);
        s.delete();
        s.push_back(8'(n >> 8));
        s.push_back(8'(n & 255));
        for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
    endtask

    // Reference: word i is bytes 2+4i..5+4i, first byte most significant, written to address i
    task automatic model_load(input bq_t s, input int aw);
        int n;
        exp_addr.delete();
        exp_data.delete();
        n = (int'(s[0]) << 8) | int'(s[1]);
        exp_err    = (n > (1 << aw));
        exp_done   = !exp_err;
        exp_cycles = 2;
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
            end
            if (n > 0) exp_cycles = 2 + 5 * n;
        end
    endtask

    // Pulse start, then offer bytes (with optional random gaps) until done/err or the budget runs out.
    // load_cycles counts clock edges after the edge that sampled start.
    task automatic run_load(input int sel, input bq_t s, input int gap, input int budget, input int start_at);
        bq_t  q;
        logic v;
        int   cyc;
        q = s;
        if (sel == 0) begin wr_a_addr.delete(); wr_a_data.delete(); end
        else          begin wr_b_addr.delete(); wr_b_data.delete(); end
        drive(sel, 1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        post_done = (sel == 0) ? a_done : b_done;
        post_hold = (sel == 0) ? a_hold : b_hold;
        cyc = 0;
        while (cyc < budget) begin
            v = (q.size() > 0) && ($urandom_range(99) >= gap);
            drive(sel, cyc == start_at, v, (q.size() > 0) ? q[0] : 8'h00);
            @(negedge clk);
            if (v && ready_of(sel)) void'(q.pop_front());
            @(posedge clk); #1;
            cyc++;
            if (fin_of(sel)) break;
        end
        drive(sel, 1'b0, 1'b0, 8'h00);
        load_cycles = cyc;
    endtask

    task automatic test_reset();
        n_checks++; if (a_wea   !== 4'b0000) begin n_fail++; $display("FAIL reset_wea: got %b want 0000", a_wea); end
        n_checks++; if (a_addra !== '0)      begin n_fail++; $display("FAIL reset_addra: got %0d want 0", a_addra); end
        n_checks++; if (a_dina  !== 32'h0)   begin n_fail++; $display("FAIL reset_dina: got %h want 0", a_dina); end
        n_checks++; if (a_ready !== 1'b0)    begin n_fail++; $display("FAIL reset_ready: got %b want 0", a_ready); end
        n_checks++; if (a_busy  !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_checks++; if (a_done  !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %b want 0", a_done); end
        n_checks++; if (a_err   !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b want 0", a_err); end
        n_checks++; if (a_hold  !== 1'b1)    begin n_fail++; $display("FAIL reset_hold: got %b want 1", a_hold); end
    endtask

    task automatic test_two_words();
        bq_t s;
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_load(0, s, 0, 100, -1);
        n_checks++;
        if (wr_a_addr.size() != 2) begin n_fail++; $display("FAIL two_words_count: got %0d want 2", wr_a_addr.size()); end
        else begin
            n_checks++;
            if (wr_a_addr[0] != 0 || wr_a_data[0] !== 32'h12345678) begin
                n_fail++; $display("FAIL two_words_w0: got @%0d %h want @0 12345678", wr_a_addr[0], wr_a_data[0]);
            end
            n_checks++;
            if (wr_a_addr[1] != 1 || wr_a_data[1] !== 32'h9ABCDEF0) begin
                n_fail++; $display("FAIL two_words_w1: got @%0d %h want @1 9abcdef0", wr_a_addr[1], wr_a_data[1]);
            end
        end
        n_checks++; if (load_cycles != 12) begin n_fail++; $display("FAIL two_words_cycles: got %0d want 12", load_cycles); end
        n_checks++; if (a_done !== 1'b1)   begin n_fail++; $display("FAIL two_words_done: got %b want 1", a_done); end
        n_checks++; if (a_hold !== 1'b0)   begin n_fail++; $display("FAIL two_words_hold: got %b want 0", a_hold); end
        n_checks++; if (a_busy !== 1'b0)   begin n_fail++; $display("FAIL two_words_busy: got %b want 0", a_busy); end
    endtask

    task automatic test_zero_len();
        bq_t s;
        s = '{8'h00, 8'h00};
        run_load(0, s, 0, 50, -1);
        n_checks++; if (wr_a_addr.size() != 0) begin n_fail++; $display("FAIL zero_len_writes: got %0d want 0", wr_a_addr.size()); end
        n_checks++; if (load_cycles != 2)      begin n_fail++; $display("FAIL zero_len_cycles: got %0d want 2", load_cycles); end
        n_checks++; if (a_done !== 1'b1)       begin n_fail++; $display("FAIL zero_len_done: got %b want 1", a_done); end
    endtask

    task automatic test_len_limit();
        bq_t s;
        make_stream(5, s);
        run_load(1, s, 0, 50, -1);
        n_checks++; if (b_err   !== 1'b1)      begin n_fail++; $display("FAIL too_long_err: got %b want 1", b_err); end
        n_checks++; if (b_done  !== 1'b0)      begin n_fail++; $display("FAIL too_long_done: got %b want 0", b_done); end
        n_checks++; if (b_hold  !== 1'b1)      begin n_fail++; $display("FAIL too_long_hold: got %b want 1", b_hold); end
        n_checks++; if (b_ready !== 1'b0)      begin n_fail++; $display("FAIL too_long_ready: got %b want 0", b_ready); end
        n_checks++; if (wr_b_addr.size() != 0) begin n_fail++; $display("FAIL too_long_writes: got %0d want 0", wr_b_addr.size()); end
        // Exactly 2^ADDR_W words is the largest legal image
        make_stream(4, s);
        model_load(s, AW_B);
        run_load(1, s, 0, 100, -1);
        n_checks++;
        if (wr_b_addr.size() != exp_addr.size()) begin
            n_fail++; $display("FAIL full_depth_count: got %0d want %0d", wr_b_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < wr_b_addr.size(); i++) begin
            n_checks++;
            if (wr_b_addr[i] != exp_addr[i] || wr_b_data[i] !== exp_data[i]) begin
                n_fail++; $display("FAIL full_depth_w%0d: got @%0d %h want @%0d %h", i, wr_b_addr[i], wr_b_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_checks++; if (b_done !== 1'b1)           begin n_fail++; $display("FAIL full_depth_done: got %b want 1", b_done); end
        n_checks++; if (load_cycles != exp_cycles) begin n_fail++; $display("FAIL full_depth_cycles: got %0d want %0d", load_cycles, exp_cycles); end
    endtask

    task automatic test_gaps();
        bq_t s;
        for (int r = 0; r < 3; r++) begin
            make_stream(3, s);
            model_load(s, AW_A);
            run_load(0, s, 40, 400, -1);
            n_checks++;
            if (wr_a_addr.size() != exp_addr.size()) begin
                n_fail++; $display("FAIL gaps_count: got %0d want %0d", wr_a_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < wr_a_addr.size(); i++) begin
                n_checks++;
                if (wr_a_addr[i] != exp_addr[i] || wr_a_data[i] !== exp_data[i]) begin
                    n_fail++; $display("FAIL gaps_w%0d: got @%0d %h want @%0d %h", i, wr_a_addr[i], wr_a_data[i], exp_addr[i], exp_data[i]);
                end
            end
            n_checks++; if (a_done !== exp_done)       begin n_fail++; $display("FAIL gaps_done: got %b want %b", a_done, exp_done); end
            n_checks++; if (load_cycles < exp_cycles)  begin n_fail++; $display("FAIL gaps_cycles: got %0d want >= %0d", load_cycles, exp_cycles); end
        end
    endtask

    task automatic test_rst_mid_word();
        bq_t s;
        make_stream(1, s);
        // Four edges: two length bytes and two data bytes
        run_load(0, s, 0, 4, -1);
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL mid_word_busy: got %b want 1", a_busy); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (a_wea   !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_wea: got %b want 0000", a_wea); end
        n_checks++; if (a_busy  !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", a_busy); end
        n_checks++; if (a_ready !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", a_ready); end
        n_checks++; if (a_addra !== '0)      begin n_fail++; $display("FAIL mid_rst_addra: got %0d want 0", a_addra); end
        n_checks++; if (a_dina  !== 32'h0)   begin n_fail++; $display("FAIL mid_rst_dina: got %h want 0", a_dina); end
        n_checks++; if (a_hold  !== 1'b1)    begin n_fail++; $display("FAIL mid_rst_hold: got %b want 1", a_hold); end
        @(posedge clk); @(negedge clk);
        n_checks++; if (wr_a_addr.size() != 0) begin n_fail++; $display("FAIL mid_rst_writes: got %0d want 0", wr_a_addr.size()); end
        rst = 1'b0;
        make_stream(1, s);
        model_load(s, AW_A);
        run_load(0, s, 0, 50, -1);
        n_checks++;
        if (wr_a_addr.size() != 1) begin n_fail++; $display("FAIL after_rst_count: got %0d want 1", wr_a_addr.size()); end
        else begin
            n_checks++;
            if (wr_a_addr[0] != 0 || wr_a_data[0] !== exp_data[0]) begin
                n_fail++; $display("FAIL after_rst_w0: got @%0d %h want @0 %h", wr_a_addr[0], wr_a_data[0], exp_data[0]);
            end
        end
        n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL after_rst_done: got %b want 1", a_done); end
    endtask

    task automatic test_start_control();
        bq_t s;
        // start while in DATA has no effect
        make_stream(2, s);
        model_load(s, AW_A);
        run_load(0, s, 0, 100, 5);
        n_checks++;
        if (wr_a_addr.size() != 2) begin n_fail++; $display("FAIL busy_start_count: got %0d want 2", wr_a_addr.size()); end
        else begin
            n_checks++;
            if (wr_a_data[0] !== exp_data[0] || wr_a_data[1] !== exp_data[1] || wr_a_addr[1] != 1) begin
                n_fail++; $display("FAIL busy_start_data: got %h %h want %h %h", wr_a_data[0], wr_a_data[1], exp_data[0], exp_data[1]);
            end
        end
        n_checks++; if (load_cycles != 12) begin n_fail++; $display("FAIL busy_start_cycles: got %0d want 12", load_cycles); end
        // start in the first DONE cycle restarts
        n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL pre_restart_done: got %b want 1", a_done); end
        make_stream(1, s);
        model_load(s, AW_A);
        run_load(0, s, 0, 50, 6);
        n_checks++; if (post_done !== 1'b0) begin n_fail++; $display("FAIL restart_done_clear: got %b want 0", post_done); end
        n_checks++; if (post_hold !== 1'b1) begin n_fail++; $display("FAIL restart_hold: got %b want 1", post_hold); end
        n_checks++;
        if (wr_a_addr.size() != 1) begin n_fail++; $display("FAIL restart_count: got %0d want 1", wr_a_addr.size()); end
        else begin
            n_checks++;
            if (wr_a_addr[0] != 0 || wr_a_data[0] !== exp_data[0]) begin
                n_fail++; $display("FAIL restart_w0: got @%0d %h want @0 %h", wr_a_addr[0], wr_a_data[0], exp_data[0]);
            end
        end
        // That load pulsed start during its WRITE -> DONE cycle: it must have been ignored
        n_checks++; if (load_cycles != 7) begin n_fail++; $display("FAIL write_start_cycles: got %0d want 7", load_cycles); end
        @(posedge clk); #1;
        n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL write_start_done: got %b want 1", a_done); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL write_start_busy: got %b want 0", a_busy); end
    endtask

    task automatic test_back_to_back();
        bq_t s;
        int  n, gap;
        for (int r = 0; r < 4; r++) begin
            n   = $urandom_range(1, 8);
            gap = (r == 0) ? 0 : $urandom_range(0, 50);
            make_stream(n, s);
            model_load(s, AW_A);
            run_load(0, s, gap, 600, -1);
            n_checks++;
            if (wr_a_addr.size() != exp_addr.size()) begin
                n_fail++; $display("FAIL b2b_count: got %0d want %0d", wr_a_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < wr_a_addr.size(); i++) begin
                n_checks++;
                if (wr_a_addr[i] != exp_addr[i] || wr_a_data[i] !== exp_data[i]) begin
                    n_fail++; $display("FAIL b2b_w%0d: got @%0d %h want @%0d %h", i, wr_a_addr[i], wr_a_data[i], exp_addr[i], exp_data[i]);
                end
            end
            n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", a_done); end
            n_checks++;
            if ((gap == 0 && load_cycles != exp_cycles) || load_cycles < exp_cycles) begin
                n_fail++; $display("FAIL b2b_cycles: got %0d want %0d (gap %0d)", load_cycles, exp_cycles, gap);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_two_words();
        test_zero_len();
        test_len_limit();
        test_gaps();
        test_rst_mid_word();
        test_start_control();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
